// File: rtl/expected_delay_pipe.sv
// expected_delay_pipe: data+valid delay line of LATENCY cke-qualified stages; optional occupancy count under EXPECTED_DELAY_PIPE_INFLIGHT_EN
module expected_delay_pipe #(
    parameter int LATENCY       = 3,
    parameter int EXPECTED_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cke,
    input  logic [EXPECTED_BITS-1:0] s_data,
    input  logic                     s_valid,
    output logic [EXPECTED_BITS-1:0] m_data,
    output logic                     m_valid
`ifdef EXPECTED_DELAY_PIPE_INFLIGHT_EN
    ,
    output logic [((LATENCY < 1) ? 1 : $clog2(LATENCY + 1))-1:0] m_inflight
`endif
);
    localparam int IW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    if (LATENCY == 0) begin : g_pass
        assign m_data  = s_data;
        assign m_valid = s_valid;
`ifdef EXPECTED_DELAY_PIPE_INFLIGHT_EN
        assign m_inflight = '0;
`endif
    end else begin : g_pipe
        logic                     v_chain [LATENCY+1];
        logic [EXPECTED_BITS-1:0] d_chain [LATENCY+1];
        assign v_chain[0] = s_valid;
        assign d_chain[0] = s_data;
        for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
            logic                     v;
            logic [EXPECTED_BITS-1:0] d;
            // stage k: valid always advances, data only moves when the upstream entry is valid
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v <= 1'b0;
                    d <= '0;
                end else if (cke) begin
                    v <= v_chain[k-1];
                    if (v_chain[k-1]) d <= d_chain[k-1];
                end
            end
            assign v_chain[k] = v;
            assign d_chain[k] = d;
        end
        assign m_valid = v_chain[LATENCY];
        assign m_data  = d_chain[LATENCY];
`ifdef EXPECTED_DELAY_PIPE_INFLIGHT_EN
        logic [IW-1:0] cnt;
        // occupancy tracks entries entering stage 1 minus the entry leaving the last stage
        always_ff @(posedge clk or posedge reset) begin
            if (reset) cnt <= '0;
            else if (cke) cnt <= cnt + IW'(s_valid) - IW'(v_chain[LATENCY]);
        end
        assign m_inflight = cnt;
`endif
    end
endmodule

// File: tb/tb_expected_delay_pipe.sv
// tb_expected_delay_pipe: directed checks of the delay pipe at LATENCY=3 and LATENCY=0
module tb_expected_delay_pipe;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cke = 1'b1;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic [7:0] c_data = '0;
    logic       c_valid = 1'b0;
    logic [7:0] cm_data;
    logic       cm_valid;
    int checks = 0;
    int errors = 0;
`ifdef EXPECTED_DELAY_PIPE_INFLIGHT_EN
    logic [1:0] m_inflight;
    logic [0:0] cm_inflight;
`endif

    expected_delay_pipe #(.LATENCY(3), .EXPECTED_BITS(8)) u_dut (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_valid(s_valid),
        .m_data(m_data), .m_valid(m_valid)
`ifdef EXPECTED_DELAY_PIPE_INFLIGHT_EN
        , .m_inflight(m_inflight)
`endif
    );

    expected_delay_pipe #(.LATENCY(0), .EXPECTED_BITS(8)) u_comb (
        .clk(clk), .reset(reset), .cke(cke), .s_data(c_data), .s_valid(c_valid),
        .m_data(cm_data), .m_valid(cm_valid)
`ifdef EXPECTED_DELAY_PIPE_INFLIGHT_EN
        , .m_inflight(cm_inflight)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        check("reset_valid", 32'(m_valid), 0);
        check("reset_data", 32'(m_data), 0);
        reset = 1'b0;

        s_valid = 1'b1; s_data = 8'hA5;
        tick();
        s_valid = 1'b0; s_data = 8'h00;
        check("single_e1_valid", 32'(m_valid), 0);
        tick();
        check("single_e2_valid", 32'(m_valid), 0);
        tick();
        check("single_e3_valid", 32'(m_valid), 1);
        check("single_e3_data", 32'(m_data), 32'hA5);
        tick();
        check("single_e4_valid", 32'(m_valid), 0);
        check("single_hold_data", 32'(m_data), 32'hA5);

        for (int t = 0; t < 7; t++) begin
            s_valid = (t < 4);
            s_data  = (t < 4) ? 8'(t + 1) : 8'h00;
            tick();
            check($sformatf("stream_valid_%0d", t), 32'(m_valid), (t >= 2 && t <= 5) ? 1 : 0);
            check($sformatf("stream_data_%0d", t), 32'(m_data),
                  (t < 2) ? 32'hA5 : (t <= 5) ? 32'(t - 1) : 32'h04);
        end
        s_valid = 1'b0;

        s_valid = 1'b1; s_data = 8'h10;
        tick();
        s_valid = 1'b0; s_data = 8'h00;
        tick();
        cke = 1'b0;
        tick();
        check("freeze1_valid", 32'(m_valid), 0);
        check("freeze1_data", 32'(m_data), 32'h04);
        tick();
        check("freeze2_valid", 32'(m_valid), 0);
        cke = 1'b1;
        tick();
        check("freeze_out_valid", 32'(m_valid), 1);
        check("freeze_out_data", 32'(m_data), 32'h10);
        tick();
        check("freeze_after_valid", 32'(m_valid), 0);
        check("freeze_after_data", 32'(m_data), 32'h10);

        s_valid = 1'b1; s_data = 8'h77;
        tick();
        s_data = 8'h88;
        tick();
        s_valid = 1'b0; s_data = 8'h00;
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(m_valid), 0);
        check("async_rst_data", 32'(m_data), 0);
        tick();
        #2 reset = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            check($sformatf("post_rst_valid_%0d", t), 32'(m_valid), 0);
            check($sformatf("post_rst_data_%0d", t), 32'(m_data), 0);
        end

`ifdef EXPECTED_DELAY_PIPE_INFLIGHT_EN
        check("inflight_idle", 32'(m_inflight), 0);
        for (int t = 0; t < 4; t++) begin
            s_valid = (t < 3);
            s_data  = 8'(8'h20 + t);
            tick();
            check($sformatf("inflight_%0d", t), 32'(m_inflight), (t < 3) ? 32'(t + 1) : 2);
        end
        s_valid = 1'b0;
        check("inflight_comb", 32'(cm_inflight), 0);
`endif

        c_valid = 1'b1; c_data = 8'h3C;
        #1;
        check("comb_valid", 32'(cm_valid), 1);
        check("comb_data", 32'(cm_data), 32'h3C);
        c_valid = 1'b0; c_data = 8'h5A;
        #1;
        check("comb_valid_low", 32'(cm_valid), 0);
        check("comb_data2", 32'(cm_data), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
